gouram_trace_mux: RTL and testbench
===================================

Name: gouram_trace_mux

Overview:
- Parametrised multi-channel trace collector; successor to the single-stream trace wrapper.
- Accepts trace records from N_CHANNELS independent producers, e.g. per-hart or instruction/data trace units.
- Selects one producer per cycle by round-robin arbitration and stores the record, tagged with its channel ID, in a DEPTH-entry FIFO.
- Drains to the trace sink over a valid/ready interface; supports backpressure or drop-on-full operation.

Parameters:
- N_CHANNELS, 4, number of producer channels (1..16).
- TRACE_WIDTH, 128, payload bits per record.
- DEPTH, 8, FIFO entries; power of two, ≥2.
- DROP_ON_FULL, 0, 0 = backpressure producers when full; 1 = accept and discard when full.
- TS_WIDTH, 32, timestamp width; used only when GOURAM_TRACE_TIMESTAMP_EN is defined.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  N_CHANNELS  per-channel record valid.
- in_data  in  N_CHANNELS*TRACE_WIDTH  channel c occupies bits [c*TRACE_WIDTH +: TRACE_WIDTH].
- in_ready  out  N_CHANNELS  per-channel grant; transfer occurs when in_valid[c] && in_ready[c].
- flush  in  1  synchronous FIFO clear.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  sink accepts head.
- out_data  out  REC_W  {[timestamp,] channel_id, payload}; REC_W = TRACE_WIDTH + CH_W (+TS_WIDTH).
- lock  out  1  FIFO full.
- level  out  $clog2(DEPTH)+1  current occupancy.
- dropped_count  out  32  saturating count of discarded records.

Behaviour:
- Reset: in_ready=0, out_valid=0, out_data=0, lock=0, level=0, dropped_count=0, rr_ptr=0, timestamp=0. Reset mid-transfer discards all FIFO contents.
- Arbitration:
  - Grant the lowest channel index ≥ rr_ptr with in_valid set; if none, wrap to the lowest index < rr_ptr.
  - At most one in_ready bit is high per cycle.
  - in_ready is combinational from in_valid, rr_ptr and full.
  - On a transfer, rr_ptr ← (grant+1) mod N_CHANNELS; otherwise rr_ptr holds.
- Full handling, DROP_ON_FULL=0: when level==DEPTH, all in_ready=0. A full FIFO does not accept a push in the same cycle as a pop, so there is no combinational out_ready→in_ready path.
- Full handling, DROP_ON_FULL=1:
  - Grant is issued regardless of full.
  - A record granted while full is discarded; dropped_count increments and saturates at 32'hFFFF_FFFF.
  - rr_ptr still advances.
- Push/pop timing:
  - A record written at edge t is visible at out_valid/out_data after edge t (one-cycle latency into an empty FIFO).
  - out_data is driven from the head register.
  - Pop occurs when out_valid && out_ready.
  - Simultaneous push and pop on a non-full, non-empty FIFO leaves level unchanged.
  - On an empty FIFO there is no bypass: a pop cannot occur, the push proceeds.
- Pointers: wr_ptr and rd_ptr are $clog2(DEPTH) bits, wrap naturally. full/empty derive from level.
- Flush:
  - Clears wr_ptr, rd_ptr and level at the next edge; out_valid=0 afterwards.
  - Overrides push and pop in the same cycle: in_ready=0 while flush is high.
  - Does not clear dropped_count, rr_ptr or timestamp.
- lock = (level==DEPTH), registered with level.
- Channel ID: CH_W = max(1, $clog2(N_CHANNELS)). With N_CHANNELS=1 the ID is always 0.

Optional Feature:
- GOURAM_TRACE_TIMESTAMP_EN defined:
  - A free-running TS_WIDTH counter increments every cycle from reset and wraps.
  - Its value at the push cycle is stored in the top TS_WIDTH bits of out_data.
  - REC_W grows accordingly.
- Not defined: no counter, REC_W = TRACE_WIDTH + CH_W.

Decomposition:
- Package gouram_trace_pkg holds:
  - function ch_width(n);
  - typedef trace_rec_t (ts, ch, payload fields, with ts under the macro);
  - localparam DROP_COUNT_MAX.
- Sub-module gouram_rr_arbiter (N requests, rr_ptr state, one-hot grant, grant index, advance input) is instantiated once. FIFO storage stays inline.

Test Plan:
- Single channel: N_CHANNELS=4, ch2 pushes 0xA5…A5 with out_ready=1 → out_valid the next cycle, out_data={2'd2, 0xA5…A5}, level returns to 0.
- Contention: all four in_valid held high, out_ready=1, rr_ptr=0 → grants ch0,ch1,ch2,ch3,ch0 on consecutive cycles; out channel IDs appear in that order.
- Backpressure: DROP_ON_FULL=0, out_ready=0, 9 pushes on ch1 → 8 accepted, lock=1, level=8, in_ready[1]=0 on the 9th. One pop → lock=0 next cycle, 9th record accepted after.
- Drop mode: DROP_ON_FULL=1, full FIFO, 3 further pushes → dropped_count=3, FIFO contents unchanged, head is still record #0.
- Flush during push: level=5, flush with in_valid[0]=1 → next cycle level=0, out_valid=0, no ch0 transfer, dropped_count unchanged.
- Async reset mid-stream: assert rst with level=4 → all outputs 0 immediately. After release, a first push on ch3 is granted, with rr_ptr restored to 0. With GOURAM_TRACE_TIMESTAMP_EN, the timestamp field restarts at 0.

Source files
------------

// File: rtl/gouram_trace_pkg.sv
// Shared types and helpers for the gouram multi-channel trace collector.
// GOURAM_TRACE_TIMESTAMP_EN adds a timestamp field to the trace record.
package gouram_trace_pkg;

    localparam logic [31:0] DROP_COUNT_MAX = 32'hFFFF_FFFF;

    localparam int DEF_TRACE_WIDTH = 128;
    localparam int DEF_CH_W        = 2;
    localparam int DEF_TS_WIDTH    = 32;

    function automatic int ch_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Record layout for the default configuration, most significant field first.
    typedef struct packed {
`ifdef GOURAM_TRACE_TIMESTAMP_EN
        logic [DEF_TS_WIDTH-1:0]    ts;
`endif
        logic [DEF_CH_W-1:0]        ch;
        logic [DEF_TRACE_WIDTH-1:0] payload;
    } trace_rec_t;

endpackage

// File: rtl/gouram_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after rr_ptr,
// wrapping around; rr_ptr moves past the winner only when advance is set.
module gouram_rr_arbiter
    import gouram_trace_pkg::*;
#(
    parameter  int N  = 4,
    localparam int IW = ch_width(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    input  logic          advance,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx,
    output logic          grant_valid
);

    logic [IW-1:0] rr_ptr;

    always_comb begin
        logic [IW:0]   sum;
        logic [IW-1:0] idx;
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        sum         = '0;
        idx         = '0;
        for (int k = 0; k < N; k++) begin
            sum = {1'b0, rr_ptr} + (IW+1)'(k);
            if (sum >= (IW+1)'(N)) begin
                sum = sum - (IW+1)'(N);
            end
            idx = sum[IW-1:0];
            if (!grant_valid && req[idx]) begin
                grant_valid = 1'b1;
                grant_idx   = idx;
            end
        end
        if (grant_valid) begin
            grant[grant_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (advance) begin
            if (int'(grant_idx) == N - 1) begin
                rr_ptr <= '0;
            end else begin
                rr_ptr <= grant_idx + 1'b1;
            end
        end
    end

endmodule

// File: rtl/gouram_trace_mux.sv
// Multi-channel trace collector: round-robin merge of producers into a FIFO.
// Define GOURAM_TRACE_TIMESTAMP_EN to prefix each record with a timestamp.
module gouram_trace_mux
    import gouram_trace_pkg::*;
#(
    parameter  int N_CHANNELS   = 4,
    parameter  int TRACE_WIDTH  = 128,
    parameter  int DEPTH        = 8,
    parameter  int DROP_ON_FULL = 0,
    parameter  int TS_WIDTH     = 32,
    localparam int CH_W         = ch_width(N_CHANNELS),
`ifdef GOURAM_TRACE_TIMESTAMP_EN
    localparam int REC_W        = TRACE_WIDTH + CH_W + TS_WIDTH,
`else
    localparam int REC_W        = TRACE_WIDTH + CH_W,
`endif
    localparam int LW           = $clog2(DEPTH) + 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [N_CHANNELS-1:0]             in_valid,
    input  logic [N_CHANNELS*TRACE_WIDTH-1:0] in_data,
    output logic [N_CHANNELS-1:0]             in_ready,
    input  logic                              flush,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [REC_W-1:0]                  out_data,
    output logic                              lock,
    output logic [LW-1:0]                     level,
    output logic [31:0]                       dropped_count
);

    localparam int AW = $clog2(DEPTH);

    if (N_CHANNELS < 1 || N_CHANNELS > 16 || DEPTH < 2 ||
        (DEPTH & (DEPTH - 1)) != 0 || TS_WIDTH < 1) begin : g_bad_cfg
        $error("gouram_trace_mux: unsupported parameter set");
    end

    logic [REC_W-1:0]        mem [DEPTH];
    logic [AW-1:0]           wr_ptr;
    logic [AW-1:0]           rd_ptr;
    logic [LW-1:0]           level_next;
    logic                    full;
    logic                    empty;
    logic                    accept_ok;
    logic                    xfer;
    logic                    push;
    logic                    pop;
    logic                    drop;
    logic [N_CHANNELS-1:0]   grant;
    logic [CH_W-1:0]         grant_idx;
    logic                    grant_valid;
    logic [TRACE_WIDTH-1:0]  sel_data;
    logic [REC_W-1:0]        wr_rec;

    gouram_rr_arbiter #(
        .N (N_CHANNELS)
    ) u_arb (
        .clk         (clk),
        .rst         (rst),
        .req         (in_valid),
        .advance     (xfer),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    assign full  = (level == LW'(DEPTH));
    assign empty = (level == '0);

    // Full only blocks producers in backpressure mode; drop mode keeps granting.
    assign accept_ok = !rst && !flush && (DROP_ON_FULL != 0 || !full);
    assign in_ready  = accept_ok ? grant : '0;
    assign xfer      = accept_ok && grant_valid;
    assign push      = xfer && !full;
    assign drop      = xfer && full;
    assign pop       = !flush && !empty && out_ready;

    assign sel_data  = in_data[grant_idx*TRACE_WIDTH +: TRACE_WIDTH];

`ifdef GOURAM_TRACE_TIMESTAMP_EN
    logic [TS_WIDTH-1:0] ts;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ts <= '0;
        end else begin
            ts <= ts + 1'b1;
        end
    end

    assign wr_rec = {ts, grant_idx, sel_data};
`else
    assign wr_rec = {grant_idx, sel_data};
`endif

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_rec;
        end
    end

    assign out_valid = !empty;
    assign out_data  = empty ? '0 : mem[rd_ptr];

    always_comb begin
        level_next = level;
        if (flush) begin
            level_next = '0;
        end else if (push && !pop) begin
            level_next = level + 1'b1;
        end else if (pop && !push) begin
            level_next = level - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            lock   <= 1'b0;
        end else begin
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
            end
            level <= level_next;
            lock  <= (level_next == LW'(DEPTH));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dropped_count <= '0;
        end else if (drop && dropped_count != DROP_COUNT_MAX) begin
            dropped_count <= dropped_count + 32'd1;
        end
    end

endmodule

// File: tb/tb_gouram_trace_mux.sv
// Bench for gouram_trace_mux: a backpressure and a drop-mode instance share
// stimulus and are both checked against a queue-based reference model.
module tb_gouram_trace_mux;

    localparam int N     = 4;
    localparam int TW    = 32;
    localparam int DEPTH = 8;
    localparam int LW    = 4;
`ifdef GOURAM_TRACE_TIMESTAMP_EN
    localparam int RW    = TW + 2 + 32;
`else
    localparam int RW    = TW + 2;
`endif

    typedef logic [RW-1:0] rec_t;

    typedef struct {
        logic [N-1:0]  v;
        logic          ordy;
        logic [N-1:0]  er;
        logic [LW-1:0] elev;
        logic          eov;
        logic [1:0]    ech;
    } vec_t;

    logic            clk;
    logic            rst;
    logic [N-1:0]    in_valid;
    logic [N*TW-1:0] in_data;
    logic            flush;
    logic            out_ready;

    logic [N-1:0]    a_in_ready, b_in_ready;
    logic            a_out_valid, b_out_valid;
    rec_t            a_out_data, b_out_data;
    logic            a_lock, b_lock;
    logic [LW-1:0]   a_level, b_level;
    logic [31:0]     a_dropped, b_dropped;

    int total = 0;
    int bad   = 0;

    rec_t        mq [2][$];
    int          rr_m [2];
    logic [31:0] drp [2];
    logic [31:0] ts_m;
    vec_t        tbl [7];

    gouram_trace_mux #(
        .N_CHANNELS (N), .TRACE_WIDTH (TW), .DEPTH (DEPTH),
        .DROP_ON_FULL (0), .TS_WIDTH (32)
    ) dut_bp (
        .clk (clk), .rst (rst), .in_valid (in_valid), .in_data (in_data),
        .in_ready (a_in_ready), .flush (flush), .out_valid (a_out_valid),
        .out_ready (out_ready), .out_data (a_out_data), .lock (a_lock),
        .level (a_level), .dropped_count (a_dropped)
    );

    gouram_trace_mux #(
        .N_CHANNELS (N), .TRACE_WIDTH (TW), .DEPTH (DEPTH),
        .DROP_ON_FULL (1), .TS_WIDTH (32)
    ) dut_dr (
        .clk (clk), .rst (rst), .in_valid (in_valid), .in_data (in_data),
        .in_ready (b_in_ready), .flush (flush), .out_valid (b_out_valid),
        .out_ready (out_ready), .out_data (b_out_data), .lock (b_lock),
        .level (b_level), .dropped_count (b_dropped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic rec_t mk_rec(input int c);
`ifdef GOURAM_TRACE_TIMESTAMP_EN
        return {ts_m, 2'(c), in_data[c*TW +: TW]};
`else
        return {2'(c), in_data[c*TW +: TW]};
`endif
    endfunction

    // Grant the first valid channel scanning upward from the model pointer.
    function automatic logic [N-1:0] exp_grant(input int m);
        logic [N-1:0] g;
        g = '0;
        if (rst || flush) return g;
        if (m == 0 && mq[0].size() == DEPTH) return g;
        for (int k = 0; k < N; k++) begin
            if (in_valid[(rr_m[m] + k) % N]) begin
                g[(rr_m[m] + k) % N] = 1'b1;
                return g;
            end
        end
        return g;
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            mq[m].delete();
            rr_m[m] = 0;
            drp[m]  = '0;
        end
        ts_m = '0;
    endtask

    task automatic model_update(input int m, input logic [N-1:0] g);
        int sz;
        int c;
        sz = mq[m].size();
        c  = -1;
        for (int k = 0; k < N; k++) if (g[k]) c = k;
        if (flush) begin
            mq[m].delete();
        end else begin
            if (sz > 0 && out_ready) void'(mq[m].pop_front());
            if (c >= 0) begin
                if (sz == DEPTH) begin
                    if (drp[m] != 32'hFFFF_FFFF) drp[m] = drp[m] + 1;
                end else begin
                    mq[m].push_back(mk_rec(c));
                end
            end
        end
        if (c >= 0) rr_m[m] = (c + 1) % N;
    endtask

    task automatic check_dut(input int m, input logic [N-1:0] g,
                             input logic [N-1:0] ir, input logic ov,
                             input rec_t od, input logic lk,
                             input logic [LW-1:0] lv, input logic [31:0] dc);
        int   sz;
        rec_t head;
        sz   = mq[m].size();
        head = (sz > 0) ? mq[m][0] : '0;
        chk($sformatf("m%0d in_ready", m), 128'(ir), 128'(g));
        chk($sformatf("m%0d out_valid", m), 128'(ov), 128'(sz > 0));
        chk($sformatf("m%0d out_data", m), 128'(od), 128'(head));
        chk($sformatf("m%0d lock", m), 128'(lk), 128'(sz == DEPTH));
        chk($sformatf("m%0d level", m), 128'(lv), 128'(sz));
        chk($sformatf("m%0d dropped", m), 128'(dc), 128'(drp[m]));
    endtask

    // Called just after a falling edge with inputs already applied.
    task automatic step();
        logic [N-1:0] ga;
        logic [N-1:0] gb;
        #1;
        ga = exp_grant(0);
        gb = exp_grant(1);
        check_dut(0, ga, a_in_ready, a_out_valid, a_out_data, a_lock,
                  a_level, a_dropped);
        check_dut(1, gb, b_in_ready, b_out_valid, b_out_data, b_lock,
                  b_level, b_dropped);
        @(posedge clk);
        model_update(0, ga);
        model_update(1, gb);
        ts_m = ts_m + 1;
        @(negedge clk);
    endtask

    task automatic set_data(input int seed);
        for (int c = 0; c < N; c++) in_data[c*TW +: TW] = 32'(seed * 16 + c);
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        in_valid  = '0;
        flush     = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = '0;
        in_data   = '0;
        flush     = 1'b0;
        out_ready = 1'b0;
        model_reset();
        #1;
        chk("reset in_ready", 128'(a_in_ready), 128'(0));
        chk("reset out_valid", 128'(a_out_valid), 128'(0));
        chk("reset out_data", 128'(a_out_data), 128'(0));
        chk("reset level", 128'(a_level), 128'(0));
        chk("reset lock", 128'(a_lock), 128'(0));
        chk("reset dropped", 128'(b_dropped), 128'(0));
        do_reset();

        // Single channel: ch2 pushes an A5 pattern.
        out_ready = 1'b1;
        in_data   = '0;
        in_data[2*TW +: TW] = 32'hA5A5_A5A5;
        in_valid  = 4'b0100;
        step();
        in_valid = '0;
        #1;
        chk("single out_valid", 128'(a_out_valid), 128'(1));
        chk("single out_data", 128'(a_out_data[TW+1:0]),
            128'({2'd2, 32'hA5A5_A5A5}));
        step();
        #1;
        chk("single level", 128'(a_level), 128'(0));

        // Contention from a fresh rr pointer.
        do_reset();
        tbl[0] = '{4'hF, 1'b1, 4'h1, 4'd0, 1'b0, 2'd0};
        tbl[1] = '{4'hF, 1'b1, 4'h2, 4'd1, 1'b1, 2'd0};
        tbl[2] = '{4'hF, 1'b1, 4'h4, 4'd1, 1'b1, 2'd1};
        tbl[3] = '{4'hF, 1'b1, 4'h8, 4'd1, 1'b1, 2'd2};
        tbl[4] = '{4'hF, 1'b1, 4'h1, 4'd1, 1'b1, 2'd3};
        tbl[5] = '{4'h0, 1'b1, 4'h0, 4'd1, 1'b1, 2'd0};
        tbl[6] = '{4'h0, 1'b1, 4'h0, 4'd0, 1'b0, 2'd0};
        for (int i = 0; i < 7; i++) begin
            in_valid  = tbl[i].v;
            out_ready = tbl[i].ordy;
            set_data(i);
            #1;
            chk($sformatf("tbl%0d in_ready", i), 128'(a_in_ready), 128'(tbl[i].er));
            chk($sformatf("tbl%0d level", i), 128'(a_level), 128'(tbl[i].elev));
            chk($sformatf("tbl%0d out_valid", i), 128'(a_out_valid), 128'(tbl[i].eov));
            if (tbl[i].eov)
                chk($sformatf("tbl%0d ch", i), 128'(a_out_data[TW +: 2]),
                    128'(tbl[i].ech));
            step();
        end

        // Fill on ch1 with the sink stalled.
        do_reset();
        out_ready = 1'b0;
        in_valid  = 4'b0010;
        for (int i = 0; i < 8; i++) begin
            set_data(100 + i);
            step();
        end
        #1;
        chk("bp lock", 128'(a_lock), 128'(1));
        chk("bp level", 128'(a_level), 128'(8));
        chk("bp 9th in_ready", 128'(a_in_ready), 128'(0));
        chk("drop 9th in_ready", 128'(b_in_ready), 128'(4'b0010));
        for (int i = 0; i < 3; i++) begin
            set_data(200 + i);
            step();
        end
        #1;
        chk("drop count", 128'(b_dropped), 128'(3));
        chk("drop level", 128'(b_level), 128'(8));
        chk("drop head", 128'(b_out_data[TW-1:0]), 128'(32'(100 * 16 + 1)));
        chk("bp dropped", 128'(a_dropped), 128'(0));
        in_valid  = '0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        #1;
        chk("pop unlock", 128'(a_lock), 128'(0));
        chk("pop level", 128'(a_level), 128'(7));
        in_valid = 4'b0010;
        set_data(300);
        #1;
        chk("refill in_ready", 128'(a_in_ready), 128'(4'b0010));
        step();
        #1;
        chk("refill level", 128'(a_level), 128'(8));

        // Drain to five entries, then flush while ch0 is requesting.
        in_valid  = '0;
        out_ready = 1'b1;
        repeat (3) step();
        out_ready = 1'b0;
        #1;
        chk("pre-flush level", 128'(a_level), 128'(5));
        flush    = 1'b1;
        in_valid = 4'b0001;
        #1;
        chk("flush in_ready", 128'(a_in_ready | b_in_ready), 128'(0));
        step();
        flush    = 1'b0;
        in_valid = '0;
        #1;
        chk("flush level", 128'(a_level), 128'(0));
        chk("flush out_valid", 128'(b_out_valid), 128'(0));
        chk("flush dropped", 128'(b_dropped), 128'(3));

        // Asynchronous reset with four records queued.
        in_valid = 4'b0010;
        repeat (4) begin
            set_data($urandom_range(0, 1000));
            step();
        end
        in_valid = '0;
        #2;
        rst = 1'b1;
        #1;
        chk("arst level", 128'(a_level), 128'(0));
        chk("arst out_valid", 128'(a_out_valid | b_out_valid), 128'(0));
        chk("arst out_data", 128'(a_out_data | b_out_data), 128'(0));
        chk("arst lock", 128'(a_lock), 128'(0));
        chk("arst dropped", 128'(b_dropped), 128'(0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        in_valid = 4'b1000;
        set_data(77);
        #1;
        chk("post-rst grant", 128'(a_in_ready), 128'(4'b1000));
        step();
        in_valid = 4'b1111;
        step();
        in_valid = '0;
        step();

        // Randomised traffic with alternating sink pressure.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            in_valid  = N'($urandom);
            for (int c = 0; c < N; c++) in_data[c*TW +: TW] = $urandom;
            out_ready = ((i / 50) % 2 == 0) ? ($urandom_range(0, 3) == 0)
                                             : ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 60) == 0);
            step();
        end
        flush = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
